seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the multiplexed 7-segment display driver.
- Samples the scanned digit-select bus (SA) and the active-low segment bus (LED), then decodes each stable digit slot back to BCD.
- Assembles the four slots into a frame and pulses FRAME_VALID when a full frame is captured.
- Used for board-level self-check, loopback test and readback of the displayed time.

---
 rtl/seg_scan_decoder.sv | 175 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receive-side decoder for a multiplexed 7-segment display bus. Samples the
//   active-low digit select (SA) and segment (LED) buses on each ENABLE strobe,
//   accepts a digit slot once its pattern has been stable for STABLE_CNT
//   strobes, decodes it back to BCD and publishes a 4-digit frame once all four
//   slots have been captured. An incomplete frame is abandoned after TIMEOUT
//   strobes.
//
//   Optional feature macro: SEG_ALT_GLYPH_EN
//     defined   - alternate glyphs 7C->6, 27->7, 67->9 decode without error
//     undefined - those glyphs decode to 4'hE and flag SEG_ERR
//
// Ports:
//   CLK          system clock
//   RESET        synchronous, active-high reset
//   ENABLE       one-CLK sample strobe; all state advances only when high
//   SA[3:0]      digit select, one-hot active-low, SA[0] = slot 0 (rightmost)
//   LED[7:0]     segments, active-low, LED[0]=a .. LED[6]=g, LED[7]=dp
//   DIGITS[15:0] captured frame, DIGITS[4k+3:4k] = slot k
//   FRAME_VALID  one-CLK pulse when DIGITS updates
//   SEG_ERR      frame held an undecodable glyph; updated with FRAME_VALID
//   STALL        one-CLK pulse when an incomplete frame times out

module seg_scan_decoder #(
   parameter int unsigned STABLE_CNT = 3,
   parameter int unsigned TIMEOUT    = 4095
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ENABLE,
   input  logic [3:0]  SA,
   input  logic [7:0]  LED,
   output logic [15:0] DIGITS,
   output logic        FRAME_VALID,
   output logic        SEG_ERR,
   output logic        STALL
);

   localparam logic [3:0]  StableCnt = 4'(STABLE_CNT);
   localparam logic [11:0] Timeout   = 12'(TIMEOUT);

   logic [3:0]  last_sa_q;
   logic [7:0]  last_led_q;
   logic [3:0]  stab_q, stab_d;
   logic [3:0]  mask_q, mask_d;
   logic [15:0] slots_q, slots_d;
   logic        pend_err_q, pend_err_d;
   logic [11:0] tout_q, tout_d;
   logic [15:0] digits_q, digits_d;
   logic        valid_q, valid_d;
   logic        seg_err_q, seg_err_d;
   logic        stall_q, stall_d;

   logic [3:0]  sel;
   logic        one_hot;
   logic        same;
   logic        accept;
   logic [3:0]  dec_val;
   logic        dec_err;

   // Segment glyph to BCD; blank decodes to F without error.
   always_comb begin
      dec_err = 1'b0;
      unique case (~LED[6:0])
         7'h3F:   dec_val = 4'h0;
         7'h06:   dec_val = 4'h1;
         7'h5B:   dec_val = 4'h2;
         7'h4F:   dec_val = 4'h3;
         7'h66:   dec_val = 4'h4;
         7'h6D:   dec_val = 4'h5;
         7'h7D:   dec_val = 4'h6;
         7'h07:   dec_val = 4'h7;
         7'h7F:   dec_val = 4'h8;
         7'h6F:   dec_val = 4'h9;
         7'h00:   dec_val = 4'hF;
`ifdef SEG_ALT_GLYPH_EN
         7'h7C:   dec_val = 4'h6;
         7'h27:   dec_val = 4'h7;
         7'h67:   dec_val = 4'h9;
`endif
         default: begin
            dec_val = 4'hE;
            dec_err = 1'b1;
         end
      endcase
   end

   assign sel     = ~SA;
   assign one_hot = (sel != 4'h0) && ((sel & (sel - 4'd1)) == 4'h0);
   assign same    = ({SA, LED} == {last_sa_q, last_led_q});

   always_comb begin
      stab_d     = stab_q;
      mask_d     = mask_q;
      slots_d    = slots_q;
      pend_err_d = pend_err_q;
      tout_d     = tout_q;
      digits_d   = digits_q;
      seg_err_d  = seg_err_q;
      valid_d    = 1'b0;
      stall_d    = 1'b0;
      accept     = 1'b0;
      if (ENABLE) begin
         if (same) begin
            stab_d = (stab_q == 4'hF) ? 4'hF : stab_q + 4'd1;
         end else begin
            stab_d = 4'd1;
         end
         // Accept only on the strobe where the count first hits StableCnt; the
         // extra term matters only when the count sits saturated at 15.
         accept = (stab_d == StableCnt) && !(same && (stab_q == StableCnt)) &&
                  one_hot && ((mask_q & sel) == 4'h0);
         if (accept) begin
            for (int k = 0; k < 4; k++) begin
               if (sel[k]) slots_d[4*k +: 4] = dec_val;
            end
            mask_d     = mask_q | sel;
            pend_err_d = pend_err_q | dec_err;
         end
         if (accept && (mask_d == 4'hF)) begin
            // Completion wins over a timeout on the same strobe.
            digits_d   = slots_d;
            seg_err_d  = pend_err_d;
            valid_d    = 1'b1;
            mask_d     = 4'h0;
            pend_err_d = 1'b0;
            tout_d     = 12'd0;
         end else if (mask_q != 4'h0) begin
            tout_d = tout_q + 12'd1;
            if (tout_d == Timeout) begin
               stall_d    = 1'b1;
               mask_d     = 4'h0;
               pend_err_d = 1'b0;
               tout_d     = 12'd0;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         last_sa_q  <= 4'hF;
         last_led_q <= 8'hFF;
         stab_q     <= 4'd0;
         mask_q     <= 4'h0;
         slots_q    <= 16'hFFFF;
         pend_err_q <= 1'b0;
         tout_q     <= 12'd0;
         digits_q   <= 16'hFFFF;
         valid_q    <= 1'b0;
         seg_err_q  <= 1'b0;
         stall_q    <= 1'b0;
      end else begin
         if (ENABLE) begin
            last_sa_q  <= SA;
            last_led_q <= LED;
         end
         stab_q     <= stab_d;
         mask_q     <= mask_d;
         slots_q    <= slots_d;
         pend_err_q <= pend_err_d;
         tout_q     <= tout_d;
         digits_q   <= digits_d;
         valid_q    <= valid_d;
         seg_err_q  <= seg_err_d;
         stall_q    <= stall_d;
      end
   end

   assign DIGITS      = digits_q;
   assign FRAME_VALID = valid_q;
   assign SEG_ERR     = seg_err_q;
   assign STALL       = stall_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder. Main instance uses STABLE_CNT=3 / TIMEOUT=4095;
// a second instance (STABLE_CNT=2 / TIMEOUT=8) covers the timeout path, since
// a full frame cannot fit inside 8 strobes with a stability count of 3.

module tb_seg_scan_decoder;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        ENABLE = 1'b0;
   logic [3:0]  SA = 4'hF;
   logic [7:0]  LED = 8'hFF;
   logic [15:0] DIGITS, DIGITS_T;
   logic        FRAME_VALID, SEG_ERR, STALL;
   logic        FRAME_VALID_T, SEG_ERR_T, STALL_T;

   int n_cmp = 0;
   int n_fail = 0;
   int nvalid = 0, nstall = 0, nvalid_t = 0, nstall_t = 0;
   logic [15:0] cap_digits = 16'h0, cap_digits_t = 16'h0;
   logic        cap_err = 1'b0;

   seg_scan_decoder #(.STABLE_CNT(3), .TIMEOUT(4095)) u_dut (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .SA(SA), .LED(LED),
      .DIGITS(DIGITS), .FRAME_VALID(FRAME_VALID), .SEG_ERR(SEG_ERR), .STALL(STALL)
   );

   seg_scan_decoder #(.STABLE_CNT(2), .TIMEOUT(8)) u_dut_to (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .SA(SA), .LED(LED),
      .DIGITS(DIGITS_T), .FRAME_VALID(FRAME_VALID_T), .SEG_ERR(SEG_ERR_T),
      .STALL(STALL_T)
   );

   always #5 CLK = ~CLK;

   // Pulse counters sampled away from the active edge.
   always @(negedge CLK) begin
      if (FRAME_VALID) begin
         nvalid++;
         cap_digits = DIGITS;
         cap_err = SEG_ERR;
      end
      if (STALL) nstall++;
      if (FRAME_VALID_T) begin
         nvalid_t++;
         cap_digits_t = DIGITS_T;
      end
      if (STALL_T) nstall_t++;
   end

   function automatic logic [7:0] led_of(input logic [6:0] s);
      return ~{1'b0, s};
   endfunction

   // One strobe followed by an idle cycle; returns on a quiet negedge.
   task automatic tick();
      @(negedge CLK) ENABLE = 1'b1;
      @(negedge CLK) ENABLE = 1'b0;
      @(negedge CLK);
   endtask

   task automatic hold(input logic [3:0] sa, input logic [7:0] led, input int n);
      SA = sa;
      LED = led;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b1;
      ENABLE = 1'b0;
      SA = 4'hF;
      LED = 8'hFF;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (DIGITS !== 16'hFFFF) begin n_fail++;
         $display("FAIL reset_digits got %h want ffff", DIGITS); end
      n_cmp++; if (FRAME_VALID !== 1'b0) begin n_fail++;
         $display("FAIL reset_valid got %b want 0", FRAME_VALID); end
      n_cmp++; if (SEG_ERR !== 1'b0) begin n_fail++;
         $display("FAIL reset_seg_err got %b want 0", SEG_ERR); end
      n_cmp++; if (STALL !== 1'b0) begin n_fail++;
         $display("FAIL reset_stall got %b want 0", STALL); end
   endtask

   task automatic test_basic_frame();
      int base;
      base = nvalid;
      hold(4'b1110, led_of(7'h06), 4);
      hold(4'b1101, led_of(7'h5B), 4);
      hold(4'b1011, led_of(7'h4F), 4);
      hold(4'b0111, led_of(7'h66), 2);
      n_cmp++; if (nvalid - base !== 0) begin n_fail++;
         $display("FAIL basic_no_early got %0d want 0", nvalid - base); end
      // Third stable strobe on slot 3 completes the frame one CLK later.
      @(negedge CLK) ENABLE = 1'b1;
      @(negedge CLK) ENABLE = 1'b0;
      n_cmp++; if (FRAME_VALID !== 1'b1) begin n_fail++;
         $display("FAIL basic_latency got %b want 1", FRAME_VALID); end
      n_cmp++; if (DIGITS !== 16'h4321) begin n_fail++;
         $display("FAIL basic_digits got %h want 4321", DIGITS); end
      @(negedge CLK);
      n_cmp++; if (FRAME_VALID !== 1'b0) begin n_fail++;
         $display("FAIL basic_pulse_drop got %b want 0", FRAME_VALID); end
      tick();
      n_cmp++; if (nvalid - base !== 1) begin n_fail++;
         $display("FAIL basic_count got %0d want 1", nvalid - base); end
      n_cmp++; if (SEG_ERR !== 1'b0) begin n_fail++;
         $display("FAIL basic_seg_err got %b want 0", SEG_ERR); end
   endtask

   task automatic test_glitch();
      int base;
      logic [6:0] glitch [6] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
      base = nvalid;
      hold(4'b1110, led_of(7'h6D), 4);
      hold(4'b1101, led_of(7'h3F), 4);
      for (int i = 0; i < 6; i++) hold(4'b1011, led_of(glitch[i]), 1);
      hold(4'b1011, led_of(7'h7F), 3);
      hold(4'b0111, led_of(7'h6F), 2);
      n_cmp++; if (nvalid - base !== 0) begin n_fail++;
         $display("FAIL glitch_no_early got %0d want 0", nvalid - base); end
      tick();
      n_cmp++; if (nvalid - base !== 1) begin n_fail++;
         $display("FAIL glitch_count got %0d want 1", nvalid - base); end
      n_cmp++; if (cap_digits !== 16'h9805) begin n_fail++;
         $display("FAIL glitch_digits got %h want 9805", cap_digits); end
      n_cmp++; if (cap_err !== 1'b0) begin n_fail++;
         $display("FAIL glitch_seg_err got %b want 0", cap_err); end
   endtask

   task automatic test_alt_glyph();
      int base;
      logic [15:0] exp_digits;
      logic        exp_err;
`ifdef SEG_ALT_GLYPH_EN
      exp_digits = 16'h2167;
      exp_err = 1'b0;
`else
      exp_digits = 16'h21E7;
      exp_err = 1'b1;
`endif
      base = nvalid;
      hold(4'b1110, led_of(7'h07), 4);
      hold(4'b1101, led_of(7'h7C), 4);
      hold(4'b1011, led_of(7'h06), 4);
      hold(4'b0111, led_of(7'h5B), 4);
      n_cmp++; if (nvalid - base !== 1) begin n_fail++;
         $display("FAIL alt_count got %0d want 1", nvalid - base); end
      n_cmp++; if (cap_digits !== exp_digits) begin n_fail++;
         $display("FAIL alt_digits got %h want %h", cap_digits, exp_digits); end
      n_cmp++; if (cap_err !== exp_err) begin n_fail++;
         $display("FAIL alt_seg_err got %b want %b", cap_err, exp_err); end
      hold(4'hF, 8'hFF, 3);
      n_cmp++; if (SEG_ERR !== exp_err) begin n_fail++;
         $display("FAIL alt_seg_err_held got %b want %b", SEG_ERR, exp_err); end
   endtask

   task automatic test_idle_select();
      int base;
      base = nvalid;
      hold(4'b1110, led_of(7'h4F), 4);
      hold(4'b0011, led_of(7'h06), 10);
      hold(4'hF, led_of(7'h06), 10);
      // Re-scan of a captured slot is ignored; first capture wins.
      hold(4'b1110, led_of(7'h7F), 4);
      hold(4'b1101, led_of(7'h66), 4);
      hold(4'b0011, led_of(7'h5B), 10);
      hold(4'b1011, led_of(7'h6D), 4);
      n_cmp++; if (nvalid - base !== 0) begin n_fail++;
         $display("FAIL idle_no_early got %0d want 0", nvalid - base); end
      hold(4'b0111, led_of(7'h7D), 4);
      n_cmp++; if (nvalid - base !== 1) begin n_fail++;
         $display("FAIL idle_count got %0d want 1", nvalid - base); end
      n_cmp++; if (cap_digits !== 16'h6543) begin n_fail++;
         $display("FAIL idle_digits got %h want 6543", cap_digits); end
      n_cmp++; if (SEG_ERR !== 1'b0) begin n_fail++;
         $display("FAIL idle_seg_err got %b want 0", SEG_ERR); end
   endtask

   task automatic test_timeout();
      int bv, bs;
      do_reset();
      bv = nvalid_t;
      bs = nstall_t;
      hold(4'b1110, led_of(7'h06), 2);
      hold(4'b1101, led_of(7'h5B), 2);
      hold(4'b1011, led_of(7'h4F), 2);
      hold(4'b0111, led_of(7'h66), 2);
      n_cmp++; if (cap_digits_t !== 16'h4321 || nvalid_t - bv !== 1) begin n_fail++;
         $display("FAIL to_first_frame got %h/%0d want 4321/1", cap_digits_t, nvalid_t - bv); end
      hold(4'b1110, led_of(7'h7F), 2);
      hold(4'b1101, led_of(7'h6F), 2);
      hold(4'hF, 8'hFF, 5);
      n_cmp++; if (nstall_t - bs !== 0) begin n_fail++;
         $display("FAIL to_no_early_stall got %0d want 0", nstall_t - bs); end
      tick();
      n_cmp++; if (nstall_t - bs !== 1) begin n_fail++;
         $display("FAIL to_stall got %0d want 1", nstall_t - bs); end
      n_cmp++; if (STALL_T !== 1'b0) begin n_fail++;
         $display("FAIL to_stall_drop got %b want 0", STALL_T); end
      hold(4'hF, 8'hFF, 2);
      n_cmp++; if (DIGITS_T !== 16'h4321 || nvalid_t - bv !== 1) begin n_fail++;
         $display("FAIL to_digits_hold got %h/%0d want 4321/1", DIGITS_T, nvalid_t - bv); end
      hold(4'b1110, led_of(7'h6D), 2);
      hold(4'b1101, led_of(7'h7D), 2);
      hold(4'b1011, led_of(7'h07), 2);
      hold(4'b0111, led_of(7'h7F), 2);
      n_cmp++; if (cap_digits_t !== 16'h8765 || nvalid_t - bv !== 2) begin n_fail++;
         $display("FAIL to_fresh_frame got %h/%0d want 8765/2", cap_digits_t, nvalid_t - bv); end
      n_cmp++; if (nstall_t - bs !== 1) begin n_fail++;
         $display("FAIL to_stall_total got %0d want 1", nstall_t - bs); end
   endtask

   task automatic test_reset_mid_frame();
      int base;
      do_reset();
      base = nvalid;
      hold(4'b1110, led_of(7'h06), 4);
      hold(4'b1101, led_of(7'h5B), 4);
      hold(4'b1011, led_of(7'h4F), 4);
      do_reset();
      n_cmp++; if (DIGITS !== 16'hFFFF) begin n_fail++;
         $display("FAIL mid_reset_digits got %h want ffff", DIGITS); end
      hold(4'b0111, led_of(7'h66), 4);
      n_cmp++; if (nvalid - base !== 0 || DIGITS !== 16'hFFFF) begin n_fail++;
         $display("FAIL mid_lone_slot got %0d/%h want 0/ffff", nvalid - base, DIGITS); end
      hold(4'b1110, led_of(7'h6F), 4);
      hold(4'b1101, led_of(7'h7F), 4);
      hold(4'b1011, led_of(7'h07), 4);
      n_cmp++; if (nvalid - base !== 1) begin n_fail++;
         $display("FAIL mid_count got %0d want 1", nvalid - base); end
      n_cmp++; if (cap_digits !== 16'h4789) begin n_fail++;
         $display("FAIL mid_digits got %h want 4789", cap_digits); end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_glitch();
      test_alt_glyph();
      test_idle_select();
      test_timeout();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
